// File: rtl/led_display_sequencer.sv
// Round-robin sharing of one 7-segment digit and one RGB LED between two requesters.
// A granted requester's digit/colour are shown for DWELL_TICKS ticks, then the display is
// blanked for BLANK_TICKS ticks, then a one-cycle done pulse is issued. All outputs registered.
module led_display_sequencer #(
  parameter int unsigned TICK_DIV       = 4000000,
  parameter int unsigned DWELL_TICKS    = 4,
  parameter int unsigned BLANK_TICKS    = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [1:0] i_req,
  input  logic [3:0] i_digit0,
  input  logic [3:0] i_digit1,
  input  logic [2:0] i_color0,
  input  logic [2:0] i_color1,
  output logic [1:0] o_gnt,
  output logic [1:0] o_done,
  output logic       o_busy,
  output logic [6:0] o_seg,
  output logic [2:0] o_rgb
);

  localparam int unsigned PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned MaxTicks = (DWELL_TICKS > BLANK_TICKS) ? DWELL_TICKS : BLANK_TICKS;
  localparam int unsigned TW       = (MaxTicks > 1) ? $clog2(MaxTicks) : 1;

  localparam logic [PW-1:0] PrescLast = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] DwellLast = TW'(DWELL_TICKS - 1);
  localparam logic [TW-1:0] BlankLast = TW'(BLANK_TICKS - 1);
  localparam logic [6:0]    SegOff    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

  state_e        r_state, w_state_d;
  logic          r_last, w_last_d;
  logic [3:0]    r_digit, w_digit_d;
  logic [2:0]    r_color, w_color_d;
  logic [TW-1:0] r_ticks, w_ticks_d;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_gnt, w_gnt_d;
  logic [1:0]    r_done, w_done_d;
  logic          r_busy, w_busy_d;
  logic [6:0]    r_seg, w_seg_d;
  logic [2:0]    r_rgb, w_rgb_d;
  logic          w_tick;
  logic          w_presc_clr;
  logic          w_win;

  // Hex digit to {a..g} pattern, polarity applied at the end.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return SEG_ACTIVE_LOW ? ~s : s;
  endfunction

  assign w_tick = (r_presc == PrescLast);

  // Tick prescaler; restarted on grant so every phase is a whole number of ticks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc <= '0;
    end else if (w_presc_clr || w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Arbitration, phase sequencing and next values of the registered outputs.
  always_comb begin
    w_state_d   = r_state;
    w_last_d    = r_last;
    w_digit_d   = r_digit;
    w_color_d   = r_color;
    w_ticks_d   = r_ticks;
    w_gnt_d     = '0;
    w_done_d    = '0;
    w_presc_clr = 1'b0;
    w_win       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|i_req) begin
          // With both requesting, the one not served last wins.
          w_win       = (i_req == 2'b11) ? ~r_last : i_req[1];
          w_gnt_d     = w_win ? 2'b10 : 2'b01;
          w_last_d    = w_win;
          w_digit_d   = w_win ? i_digit1 : i_digit0;
          w_color_d   = w_win ? i_color1 : i_color0;
          w_ticks_d   = '0;
          w_presc_clr = 1'b1;
          w_state_d   = StShow;
        end
      end
      StShow: begin
        if (w_tick) begin
          if (r_ticks == DwellLast) begin
            w_ticks_d = '0;
            if (BLANK_TICKS == 0) begin
              w_state_d = StIdle;
              w_done_d  = r_last ? 2'b10 : 2'b01;
            end else begin
              w_state_d = StBlank;
            end
          end else begin
            w_ticks_d = r_ticks + 1'b1;
          end
        end
      end
      StBlank: begin
        if (w_tick) begin
          if (r_ticks == BlankLast) begin
            w_ticks_d = '0;
            w_state_d = StIdle;
            w_done_d  = r_last ? 2'b10 : 2'b01;
          end else begin
            w_ticks_d = r_ticks + 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
    w_busy_d = (w_state_d != StIdle);
    w_seg_d  = (w_state_d == StShow) ? hex_to_seg(w_digit_d) : SegOff;
    w_rgb_d  = (w_state_d == StShow) ? w_color_d : 3'b000;
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_last  <= 1'b1;
      r_digit <= '0;
      r_color <= '0;
      r_ticks <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_seg   <= SegOff;
      r_rgb   <= '0;
    end else begin
      r_state <= w_state_d;
      r_last  <= w_last_d;
      r_digit <= w_digit_d;
      r_color <= w_color_d;
      r_ticks <= w_ticks_d;
      r_gnt   <= w_gnt_d;
      r_done  <= w_done_d;
      r_busy  <= w_busy_d;
      r_seg   <= w_seg_d;
      r_rgb   <= w_rgb_d;
    end
  end

  assign o_gnt  = r_gnt;
  assign o_done = r_done;
  assign o_busy = r_busy;
  assign o_seg  = r_seg;
  assign o_rgb  = r_rgb;

endmodule

// File: tb/tb_led_display_sequencer.sv
// Bench: two instances (index 0 with one blank tick, index 1 with none) share stimulus and are
// checked every cycle against a transaction-timeline model, plus literal pins on key cycles.
module tb_led_display_sequencer;

  localparam int unsigned TD = 4;
  localparam int unsigned DW = 3;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic [1:0] req    = '0;
  logic [3:0] digit0 = '0;
  logic [3:0] digit1 = '0;
  logic [2:0] color0 = '0;
  logic [2:0] color1 = '0;

  logic [1:0] gnt_o  [2];
  logic [1:0] done_o [2];
  logic       busy_o [2];
  logic [6:0] seg_o  [2];
  logic [2:0] rgb_o  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  led_display_sequencer #(
    .TICK_DIV(TD), .DWELL_TICKS(DW), .BLANK_TICKS(1), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_b1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_digit0(digit0), .i_digit1(digit1), .i_color0(color0), .i_color1(color1),
    .o_gnt(gnt_o[0]), .o_done(done_o[0]), .o_busy(busy_o[0]), .o_seg(seg_o[0]), .o_rgb(rgb_o[0])
  );

  led_display_sequencer #(
    .TICK_DIV(TD), .DWELL_TICKS(DW), .BLANK_TICKS(0), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut_b0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req),
    .i_digit0(digit0), .i_digit1(digit1), .i_color0(color0), .i_color1(color1),
    .o_gnt(gnt_o[1]), .o_done(done_o[1]), .o_busy(busy_o[1]), .o_seg(seg_o[1]), .o_rgb(rgb_o[1])
  );

  // Active-high a..g patterns for 0..F.
  logic [6:0] seg_tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model: a transaction is the grant cycle plus a count of cycles elapsed since it.
  bit         m_act  [2];
  int         m_k    [2];
  bit         m_last [2];
  logic [3:0] m_dig  [2];
  logic [2:0] m_col  [2];
  logic [1:0] e_gnt  [2];
  logic [1:0] e_done [2];
  logic       e_busy [2];
  logic [6:0] e_seg  [2];
  logic [2:0] e_rgb  [2];

  function automatic int blank_of(input int i);
    return (i == 0) ? 1 : 0;
  endfunction

  task automatic set_idle(input int i);
    e_busy[i] = 1'b0;
    e_seg[i]  = 7'h7F;
    e_rgb[i]  = 3'b000;
  endtask

  task automatic set_show(input int i);
    e_busy[i] = 1'b1;
    e_seg[i]  = ~seg_tbl[m_dig[i]];
    e_rgb[i]  = m_col[i];
  endtask

  task automatic model_step(input int i, input bit in_reset);
    bit w;
    e_gnt[i]  = '0;
    e_done[i] = '0;
    if (in_reset) begin
      m_act[i]  = 1'b0;
      m_last[i] = 1'b1;
      m_k[i]    = 0;
      set_idle(i);
    end else if (m_act[i]) begin
      m_k[i] = m_k[i] + 1;
      if (m_k[i] < int'(DW * TD)) begin
        set_show(i);
      end else if (m_k[i] < (int'(DW) + blank_of(i)) * int'(TD)) begin
        e_busy[i] = 1'b1;
        e_seg[i]  = 7'h7F;
        e_rgb[i]  = 3'b000;
      end else begin
        e_done[i] = m_last[i] ? 2'b10 : 2'b01;
        m_act[i]  = 1'b0;
        set_idle(i);
      end
    end else if (req != 2'b00) begin
      w         = (req == 2'b11) ? !m_last[i] : req[1];
      m_last[i] = w;
      m_dig[i]  = w ? digit1 : digit0;
      m_col[i]  = w ? color1 : color0;
      m_act[i]  = 1'b1;
      m_k[i]    = 0;
      e_gnt[i]  = w ? 2'b10 : 2'b01;
      set_show(i);
    end else begin
      set_idle(i);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) model_step(i, 1'b1);
    forever begin
      @(posedge clk or negedge rst_n);
      for (int i = 0; i < 2; i++) model_step(i, !rst_n);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every cycle, each instance against the model.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d.gnt", i), 32'(gnt_o[i]), 32'(e_gnt[i]));
      check($sformatf("dut%0d.done", i), 32'(done_o[i]), 32'(e_done[i]));
      check($sformatf("dut%0d.busy", i), 32'(busy_o[i]), 32'(e_busy[i]));
      check($sformatf("dut%0d.seg", i), 32'(seg_o[i]), 32'(e_seg[i]));
      check($sformatf("dut%0d.rgb", i), 32'(rgb_o[i]), 32'(e_rgb[i]));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  // Leaves the bench just after an edge with reset released: that point is cycle 0.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req   = 2'b00;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  initial begin
    int n_g1;
    int n_d1;

    // Single request, input stability, pending request from the other side.
    do_reset();
    check("reset_seg", 32'(seg_o[0]), 32'h7F);
    check("reset_busy", 32'(busy_o[0]), 32'h0);
    req = 2'b01; digit0 = 4'h1; color0 = 3'b100;
    for (int c = 1; c <= 40; c++) begin
      next_cycle();
      if (c == 1) begin
        check("a_gnt_c1", 32'(gnt_o[0]), 32'b01);
        check("a_seg_c1", 32'(seg_o[0]), 32'b1001111);
        check("a_rgb_c1", 32'(rgb_o[0]), 32'b100);
        req = 2'b00;
      end
      if (c == 4) digit0 = 4'h8;
      if (c == 5) req = 2'b10;
      if (c == 12) check("a_seg_c12", 32'(seg_o[0]), 32'b1001111);
      if (c == 13) begin
        check("a_seg_c13", 32'(seg_o[0]), 32'h7F);
        check("a_rgb_c13", 32'(rgb_o[0]), 32'h0);
        check("a_busy_c13", 32'(busy_o[0]), 32'h1);
      end
      if (c == 17) begin
        check("a_done_c17", 32'(done_o[0]), 32'b01);
        check("a_busy_c17", 32'(busy_o[0]), 32'h0);
      end
      if (c == 18) begin
        check("a_gnt_c18", 32'(gnt_o[0]), 32'b10);
        req = 2'b00;
      end
    end

    // Withdrawal: a short pulse on req1 while requester 0 is served.
    do_reset();
    req = 2'b01; digit0 = 4'h2; color0 = 3'b010;
    n_g1 = 0;
    n_d1 = 0;
    for (int c = 1; c <= 30; c++) begin
      next_cycle();
      if (gnt_o[0][1]) n_g1++;
      if (done_o[0][1]) n_d1++;
      if (c == 1) req = 2'b00;
      if (c == 5) req = 2'b10;
      if (c == 9) req = 2'b00;
      if (c == 17) check("b_done0_c17", 32'(done_o[0]), 32'b01);
    end
    check("b_no_gnt1", 32'(n_g1), 32'd0);
    check("b_no_done1", 32'(n_d1), 32'd0);

    // Contention: both held, strict alternation.
    do_reset();
    req = 2'b11; digit0 = 4'h3; digit1 = 4'hC; color0 = 3'b001; color1 = 3'b110;
    for (int c = 1; c <= 60; c++) begin
      next_cycle();
      if (c == 1) check("c_gnt_c1", 32'(gnt_o[0]), 32'b01);
      if (c == 17) check("c_done_c17", 32'(done_o[0]), 32'b01);
      if (c == 18) check("c_gnt_c18", 32'(gnt_o[0]), 32'b10);
      if (c == 34) check("c_done_c34", 32'(done_o[0]), 32'b10);
      if (c == 35) check("c_gnt_c35", 32'(gnt_o[0]), 32'b01);
    end
    req = 2'b00;

    // Reset abort mid-show.
    do_reset();
    req = 2'b01; digit0 = 4'h5; color0 = 3'b001;
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (c == 1) req = 2'b00;
      if (c == 7) begin
        rst_n = 1'b0;
        #1;
        check("d_seg_rst", 32'(seg_o[0]), 32'h7F);
        check("d_rgb_rst", 32'(rgb_o[0]), 32'h0);
        check("d_busy_rst", 32'(busy_o[0]), 32'h0);
      end
      if (c == 8) check("d_done_rst", 32'(done_o[0]), 32'h0);
      if (c == 9) begin
        rst_n = 1'b1;
        req   = 2'b01;
      end
      if (c == 10) begin
        check("d_gnt_after", 32'(gnt_o[0]), 32'b01);
        req = 2'b00;
      end
    end

    // Decode sweep on the instance without a blank phase.
    do_reset();
    for (int d = 0; d < 16; d++) begin
      bit seen;
      int cnt;
      digit0 = 4'(d);
      color0 = 3'(d);
      req    = 2'b01;
      seen   = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        next_cycle();
        if (gnt_o[1] == 2'b01) seen = 1'b1;
      end
      check($sformatf("e_gnt_seen_%0d", d), 32'(seen), 32'd1);
      req = 2'b00;
      if (d == 0) check("e_seg_0", 32'(seg_o[1]), 32'b0000001);
      if (d == 10) check("e_seg_a", 32'(seg_o[1]), 32'b0001000);
      cnt  = 0;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        next_cycle();
        cnt++;
        if (done_o[1] == 2'b01) seen = 1'b1;
      end
      check($sformatf("e_done_seen_%0d", d), 32'(seen), 32'd1);
      check($sformatf("e_show_len_%0d", d), 32'(cnt), 32'd12);
    end

    // Random traffic with occasional resets; the model checks every cycle.
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      next_cycle();
      if ($urandom_range(0, 7) == 0) req = 2'($urandom);
      digit0 = 4'($urandom);
      digit1 = 4'($urandom);
      color0 = 3'($urandom);
      color1 = 3'($urandom);
      rst_n  = ($urandom_range(0, 249) != 0);
    end
    rst_n = 1'b1;
    req   = 2'b00;
    repeat (20) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/led_display_sequencer.md
Name: led_display_sequencer

Overview:
- Shares the board's 7-segment display (segments a..g) and RGB LED between two requesters.
- Each requester submits a hex digit and an RGB colour. The block grants one requester at a time, round-robin.
- The granted digit and colour are shown for a programmed dwell, then the display is blanked. Completion is then signalled.
- Sits between application logic (counters, status sources) and the top-level LED pins of the helloworld/blink designs.

Parameters:
- TICK_DIV, 4000000: clk cycles per display tick; legal range 1..2^24.
- DWELL_TICKS, 4: ticks the digit and colour are shown; minimum 1.
- BLANK_TICKS, 1: ticks of blank display after the dwell; 0 means no blank phase.
- SEG_ACTIVE_LOW, 1: 1 drives segments active-low (common anode); 0 drives them active-high.

Ports:
- clk  in  1  system clock (Sys_Clk0).
- rst_n  in  1  asynchronous active-low reset.
- req  in  2  request; req[i] is held high until gnt[i].
- digit0  in  4  hex value for requester 0; sampled at grant.
- digit1  in  4  hex value for requester 1; sampled at grant.
- color0  in  3  {red,green,blue} for requester 0; sampled at grant.
- color1  in  3  {red,green,blue} for requester 1; sampled at grant.
- gnt  out  2  one-cycle grant pulse, one-hot.
- done  out  2  one-cycle completion pulse, one-hot.
- busy  out  1  high in SHOW or BLANK.
- seg  out  7  {a,b,c,d,e,f,g}; seg[6]=a.
- rgb  out  3  {redled,greenled,blueled}; active-high.

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n. All outputs are registered.
- Reset values:
  - state=IDLE, gnt=0, done=0, busy=0, rgb=0.
  - seg at "all off": 7'h7F when SEG_ACTIVE_LOW=1, otherwise 0.
  - Round-robin pointer last=1, so requester 0 wins first.
  - Prescaler=0, tick counter=0.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick asserts when the count equals TICK_DIV-1, then the count wraps to 0.
  - Cleared on every grant, so phases are exact multiples of TICK_DIV cycles.
- IDLE:
  - Display is off.
  - If any req bit is high at edge n, arbitrate: a single request wins; with both requests, the requester != last wins.
  - At edge n+1: gnt[w]=1 for exactly one cycle, last<=w, the winner's digit and colour are latched, state=SHOW.
- SHOW:
  - seg shows the hex decode of the latched digit (0-F, standard patterns, inverted if SEG_ACTIVE_LOW). rgb shows the latched colour. busy=1.
  - Lasts exactly DWELL_TICKS*TICK_DIV cycles.
  - Then enters BLANK, or goes straight to the done/IDLE step if BLANK_TICKS=0.
- BLANK:
  - seg off, rgb=0, busy=1.
  - Lasts exactly BLANK_TICKS*TICK_DIV cycles.
- Completion: on entry to IDLE, done[w]=1 for one cycle and busy=0.
  - Arbitration resumes in that same cycle, so the next gnt comes at the earliest 1 cycle after done.
- Requests:
  - A req arriving during SHOW or BLANK stays pending; it is never dropped while held high.
  - A req deasserted before its grant is withdrawn, with no gnt or done for it.
  - A req from the requester currently being serviced is re-arbitrated normally after done.
- Digit/colour inputs are ignored except at the grant edge. Mid-operation changes do not affect the display.
- Reset mid-operation aborts immediately: outputs return to reset values, no done is issued, and pending requests must be re-asserted.
- Hex decode, a..g active-high:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001
  - 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111
  - C=1001110, d=0111101, E=1001111, F=1000111

Test Plan:
- Parameters for all scenarios: TICK_DIV=4, DWELL_TICKS=3, BLANK_TICKS=1, SEG_ACTIVE_LOW=1.
- Single request: req=01, digit0=1, color0=100 sampled at edge 0 -> gnt=01 at cycle 1; seg=1001111 and rgb=100 for cycles 1-12; seg=1111111 and rgb=000 for cycles 13-16; done=01 and busy=0 at cycle 17.
- Contention: req=11 held from reset -> gnt sequence 01, 10, 01, ... Each gnt comes exactly 1 cycle after the previous done. No cycle ever has two gnt bits set.
- Pending and withdrawal:
  - req1 raised at cycle 5 during requester-0 service -> gnt=10 at cycle 18.
  - Separately, req1 pulsed only during cycles 5-8 -> no gnt[1] and no done[1].
- Input stability: digit0 changed from 1 to 8 at cycle 4 -> seg stays 1001111 throughout SHOW.
- Reset abort: rst_n low at cycle 7 for 2 cycles -> seg=1111111, rgb=000, busy=0 immediately, with no done. After rst_n returns high with req=01, gnt=01 after 1 cycle.
- Decode sweep with BLANK_TICKS=0: digits 0-F in turn -> each SHOW shows the inverted table pattern, e.g. 0 gives 0000001 and A gives 0001000; done comes directly after SHOW, with no blank cycles.
